// File: rtl/mips_pkg.sv
// Purpose: shared opcode/funct constants and enums for the next-PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'd0,
    PC_SEL_JMP = 2'd1,
    PC_SEL_JR  = 2'd2,
    PC_SEL_BR  = 2'd3
  } pc_sel_e;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  // True for the two absolute-target jumps (J and JAL).
  function automatic logic is_abs_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Purpose: groups decode inputs and redirect/flush/link outputs of the next-PC sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is a freeze request from the hazard unit; no handshake.
interface pc_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic             ex_branch_taken;
  logic [1:0]       pc_sel;
  logic             flush_ifid;
  logic             flush_idex;
  logic             link_we_wb;
  logic [CNT_W-1:0] redirect_cnt;

  // Pipeline side drives decode info and consumes the redirect controls.
  modport master (
    output stall, id_opcode, id_funct, ex_branch_taken,
    input  pc_sel, flush_ifid, flush_idex, link_we_wb, redirect_cnt
  );

  // The sequencer itself.
  modport slave (
    input  stall, id_opcode, id_funct, ex_branch_taken,
    output pc_sel, flush_ifid, flush_idex, link_we_wb, redirect_cnt
  );
endinterface

// File: rtl/link_delay_pipe.sv
// Purpose: DEPTH-stage shift register carrying the JAL link-write request, with per-stage clear.
// Latency: din appears on dout DEPTH edges after it is sampled.
// Backpressure: none; shifts every cycle, clr kills a stage's incoming bit.
module link_delay_pipe #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_i,
  input  logic [DEPTH-1:0] clr_i,
  output logic             dout_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Shift by one stage; a clear bit zeroes the value landing in that stage.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = din_i & ~clr_i[0];
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1] & ~clr_i[i];
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Purpose: next-PC select, IF/ID and ID/EX flush, squashed-slot tracking, JAL link delay, redirect count.
// Latency: select and flushes are combinational; link write lands LINK_DELAY edges after JAL accept.
// Backpressure: stall freezes ID decode (jump re-evaluated later); an EX branch overrides stall.
module pc_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LINK_DELAY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_redirect_ctrl_if.slave    bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pc_sel_e          sel;
  logic             flush_ifid, flush_idex, redirect;
  logic             id_jump, id_jr, jal_load, link_out;

  // ID decode is only trusted for a real instruction that is not frozen.
  assign id_jump = (state_q == RUN) && !bus.stall && is_abs_jump(bus.id_opcode);
  assign id_jr   = (state_q == RUN) && !bus.stall &&
                   (bus.id_opcode == OP_RTYPE) && (bus.id_funct == FUNCT_JR);

  // A JAL killed by an older EX branch must never write its link.
  assign jal_load = id_jump && (bus.id_opcode == OP_JAL) && !bus.ex_branch_taken;

  // Priority redirect decode and next state; outputs held quiet during reset.
  always_comb begin
    sel        = PC_SEL_SEQ;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    redirect   = 1'b0;
    if (!rst) begin
      if (bus.ex_branch_taken) begin
        sel        = PC_SEL_BR;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        redirect   = 1'b1;
      end else if (id_jr) begin
        sel        = PC_SEL_JR;
        flush_ifid = 1'b1;
        redirect   = 1'b1;
      end else if (id_jump) begin
        sel        = PC_SEL_JMP;
        flush_ifid = 1'b1;
        redirect   = 1'b1;
      end
    end
    state_d = redirect ? SQUASH : RUN;
    cnt_d   = (redirect && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and saturating redirect counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage 0 of the link pipe is the ID/EX slot, which an EX branch flushes.
  link_delay_pipe #(
    .DEPTH (LINK_DELAY)
  ) u_link_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (jal_load),
    .clr_i  (LINK_DELAY'(bus.ex_branch_taken)),
    .dout_o (link_out)
  );

  assign bus.pc_sel       = sel;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.flush_idex   = flush_idex;
  assign bus.link_we_wb   = link_out & ~rst;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Purpose: directed self-checking bench for pc_redirect_ctrl (CNT_W=16 and CNT_W=4 instances).
// Latency: outputs checked at negedge, inputs changed 1 time unit after posedge.
// Backpressure: exercised through the stall input.
module tb_pc_redirect_ctrl;
  import mips_pkg::*;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [5:0] op;
  logic [5:0] fn;
  logic       br;
  int         checks;
  int         errors;

  pc_redirect_ctrl_if #(.CNT_W(16)) bus16 ();
  pc_redirect_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus16.stall           = stall;
  assign bus16.id_opcode       = op;
  assign bus16.id_funct        = fn;
  assign bus16.ex_branch_taken = br;
  assign bus4.stall            = stall;
  assign bus4.id_opcode        = op;
  assign bus4.id_funct         = fn;
  assign bus4.ex_branch_taken  = br;

  pc_redirect_ctrl #(.CNT_W(16), .LINK_DELAY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  pc_redirect_ctrl #(.CNT_W(4), .LINK_DELAY(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic r, input logic s, input logic [5:0] o,
                     input logic [5:0] f, input logic b, input logic [1:0] e_sel,
                     input logic e_fi, input logic e_fx, input logic e_lw, input int e_cnt);
    int e_cnt4;
    e_cnt4 = (e_cnt > 15) ? 15 : e_cnt;
    rst = r; stall = s; op = o; fn = f; br = b;
    @(negedge clk);
    checks++;
    assert (bus16.pc_sel === e_sel) else begin
      errors++;
      $error("FAIL %s pc_sel observed=%0d expected=%0d", tag, bus16.pc_sel, e_sel);
    end
    checks++;
    assert (bus16.flush_ifid === e_fi) else begin
      errors++;
      $error("FAIL %s flush_ifid observed=%0b expected=%0b", tag, bus16.flush_ifid, e_fi);
    end
    checks++;
    assert (bus16.flush_idex === e_fx) else begin
      errors++;
      $error("FAIL %s flush_idex observed=%0b expected=%0b", tag, bus16.flush_idex, e_fx);
    end
    checks++;
    assert (bus16.link_we_wb === e_lw) else begin
      errors++;
      $error("FAIL %s link_we_wb observed=%0b expected=%0b", tag, bus16.link_we_wb, e_lw);
    end
    checks++;
    assert (bus16.redirect_cnt === 16'(e_cnt)) else begin
      errors++;
      $error("FAIL %s redirect_cnt observed=%0d expected=%0d", tag, bus16.redirect_cnt, e_cnt);
    end
    checks++;
    assert (bus4.redirect_cnt === 4'(e_cnt4)) else begin
      errors++;
      $error("FAIL %s redirect_cnt4 observed=%0d expected=%0d", tag, bus4.redirect_cnt, e_cnt4);
    end
    checks++;
    assert (bus4.link_we_wb === e_lw) else begin
      errors++;
      $error("FAIL %s link_we_wb4 observed=%0b expected=%0b", tag, bus4.link_we_wb, e_lw);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; stall = 1'b0; op = 6'd0; fn = 6'd0; br = 1'b0;
    @(posedge clk);
    #1;

    // Reset: outputs quiet even with a JAL and branch presented.
    cyc("rst0", 1, 0, OP_JAL, 6'd0, 0, 2'd0, 0, 0, 0, 0);
    cyc("rst1", 1, 0, OP_J,   6'd0, 1, 2'd0, 0, 0, 0, 0);

    // JAL: redirect now, link write three cycles later.
    cyc("jal",     0, 0, OP_JAL, 6'd0, 0, 2'd1, 1, 0, 0, 0);
    cyc("jal_sq",  0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 1);
    cyc("jal_c2",  0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 1);
    cyc("jal_lw",  0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 1, 1);
    cyc("jal_c4",  0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 1);

    // JR: register redirect, no link write.
    cyc("jr",      0, 0, OP_RTYPE, FUNCT_JR, 0, 2'd2, 1, 0, 0, 1);
    cyc("jr_sq",   0, 0, 6'd0,     6'd0,     0, 2'd0, 0, 0, 0, 2);
    cyc("jr_c2",   0, 0, 6'd0,     6'd0,     0, 2'd0, 0, 0, 0, 2);
    cyc("jr_c3",   0, 0, 6'd0,     6'd0,     0, 2'd0, 0, 0, 0, 2);
    cyc("jr_c4",   0, 0, 6'd0,     6'd0,     0, 2'd0, 0, 0, 0, 2);

    // J held by stall for two cycles, fires when stall drops.
    cyc("j_st0",   0, 1, OP_J, 6'd0, 0, 2'd0, 0, 0, 0, 2);
    cyc("j_st1",   0, 1, OP_J, 6'd0, 0, 2'd0, 0, 0, 0, 2);
    cyc("j_go",    0, 0, OP_J, 6'd0, 0, 2'd1, 1, 0, 0, 2);
    cyc("j_sq",    0, 0, 6'd0, 6'd0, 0, 2'd0, 0, 0, 0, 3);

    // EX branch beats a JAL in ID; that JAL never writes its link.
    cyc("br_jal",  0, 0, OP_JAL, 6'd0, 1, 2'd3, 1, 1, 0, 3);
    cyc("br_sq",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 4);
    cyc("br_c2",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 4);
    cyc("br_c3",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 4);
    cyc("br_c4",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 4);

    // Branch, then a J seen in the squashed slot is ignored; RUN resumes.
    cyc("br2",     0, 0, 6'd0, 6'd0, 1, 2'd3, 1, 1, 0, 4);
    cyc("sq_j",    0, 0, OP_J, 6'd0, 0, 2'd0, 0, 0, 0, 5);
    cyc("run_j",   0, 0, OP_J, 6'd0, 0, 2'd1, 1, 0, 0, 5);
    cyc("run_sq",  0, 0, 6'd0, 6'd0, 0, 2'd0, 0, 0, 0, 6);

    // Branch honoured while stalled.
    cyc("br_stl",  0, 1, OP_J, 6'd0, 1, 2'd3, 1, 1, 0, 6);
    cyc("br_stl2", 0, 0, 6'd0, 6'd0, 0, 2'd0, 0, 0, 0, 7);

    // Back-to-back branches: the 4-bit counter saturates at 15.
    for (int i = 0; i < 12; i++) begin
      cyc("br_run", 0, 0, 6'd0, 6'd0, 1, 2'd3, 1, 1, 0, 7 + i);
    end
    cyc("sat",     0, 0, 6'd0, 6'd0, 0, 2'd0, 0, 0, 0, 19);

    // Reset with a link bit in flight: dropped, counters cleared.
    cyc("jal2",    0, 0, OP_JAL, 6'd0, 0, 2'd1, 1, 0, 0, 19);
    cyc("jal2_sq", 0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 20);
    cyc("mid_rst", 1, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 20);
    cyc("post0",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 0);
    cyc("post1",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 0);
    cyc("post2",   0, 0, 6'd0,   6'd0, 0, 2'd0, 0, 0, 0, 0);

    // Fresh J after reset starts from RUN.
    cyc("post_j",  0, 0, OP_J, 6'd0, 0, 2'd1, 1, 0, 0, 0);
    cyc("post_sq", 0, 0, 6'd0, 6'd0, 0, 2'd0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
